// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the block-RAM port-A arbiter.
package bram_port_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int BE_W      = XLEN / 8;
    localparam int MAX_LINES = 8192;
    localparam int MAX_AW    = $clog2(MAX_LINES);

    // Requester slots on the shared port.
    localparam int REQ_CPU    = 0;
    localparam int REQ_LOADER = 1;

    // An all-zero byte-enable marks a read access.
    localparam logic [BE_W-1:0] READ_BE = '0;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [XLEN-1:0]   wdata;
    } mem_port_req_t;

    function automatic logic is_read(input logic [BE_W-1:0] be);
        return be == READ_BE;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_arb_rr2.sv
// Two-way grant logic: round-robin, or fixed priority with a starvation
// override for the loader after it has waited MAX_WAIT+1 cycles.
module arb_rr2 #(
    parameter int FIXED_PRIORITY = 0,
    parameter int MAX_WAIT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       last_gnt;   // 1 = loader won last, so the CPU wins next tie
    logic [3:0] wait_cnt;   // cycles the loader has waited, capped at MAX_WAIT
    logic       starve;     // loader has waited one cycle beyond MAX_WAIT
    logic [1:0] req_v;

    // Requests are ignored while reset is held.
    assign req_v = rst ? 2'b00 : req;

    // One-hot grant selection from the current requests.
    always_comb begin
        // NOTE: default assignment first so every path drives gnt and no latch is inferred.
        gnt = 2'b00;
        case (req_v)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (FIXED_PRIORITY != 0)
                    gnt = starve ? 2'b10 : 2'b01;
                else
                    gnt = last_gnt ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember who won most recently for round-robin tie-breaks.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (rst)
            last_gnt <= 1'b1;
        else if (gnt != 2'b00)
            last_gnt <= gnt[1];
    end

    // Loader wait tracking for the fixed-priority starvation override.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            starve   <= 1'b0;
        end else if (gnt[1]) begin
            wait_cnt <= 4'd0;
            starve   <= 1'b0;
        end else if (req_v[1]) begin
            if (wait_cnt == 4'(MAX_WAIT))
                starve <= 1'b1;
            else
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares RAM port A between the CPU data path and the loader: arbitrates
// single-word accesses, drives the port and returns read data with a
// per-requester valid strobe one cycle after a read grant.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int LINES          = 8192,
    parameter int FIXED_PRIORITY = 0,
    parameter int MAX_WAIT       = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req,
    input  logic [$clog2(LINES)-1:0] addr0,
    input  logic [$clog2(LINES)-1:0] addr1,
    input  logic [XLEN/8-1:0]        be0,
    input  logic [XLEN/8-1:0]        be1,
    input  logic [XLEN-1:0]          wdata0,
    input  logic [XLEN-1:0]          wdata1,
    output logic [1:0]               gnt,
    output logic [1:0]               rvalid,
    output logic [XLEN-1:0]          rdata,
    output logic [$clog2(LINES)-1:0] ram_addr,
    output logic                     ram_en,
    output logic [XLEN/8-1:0]        ram_be,
    output logic [XLEN-1:0]          ram_wdata,
    input  logic [XLEN-1:0]          ram_rdata
);

    localparam int AW = $clog2(LINES);

    mem_port_req_t req_s [2];
    mem_port_req_t win;

    arb_rr2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY),
        .MAX_WAIT       (MAX_WAIT)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // Gather each requester's access into the shared request format.
    always_comb begin
        req_s[REQ_CPU].addr     = MAX_AW'(addr0);
        req_s[REQ_CPU].be       = be0;
        req_s[REQ_CPU].wdata    = wdata0;
        req_s[REQ_LOADER].addr  = MAX_AW'(addr1);
        req_s[REQ_LOADER].be    = be1;
        req_s[REQ_LOADER].wdata = wdata1;
    end

    // Select the winner's access; an idle port drives all zeros.
    always_comb begin
        win = '0;
        if (gnt[REQ_CPU])
            win = req_s[REQ_CPU];
        else if (gnt[REQ_LOADER])
            win = req_s[REQ_LOADER];
    end

    assign ram_en    = |gnt;
    assign ram_addr  = AW'(win.addr);
    assign ram_be    = win.be;
    assign ram_wdata = win.wdata;

    // Read data returns one cycle after a read grant; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rvalid <= 2'b00;
        else
            rvalid <= gnt & {2{is_read(win.be)}};
    end

    assign rdata = ram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority (MAX_WAIT=3)
// instance share the same stimulus, each with its own RAM and its own
// behavioural reference model.
module tb_bram_port_arbiter;
    import bram_port_arbiter_pkg::*;

    localparam int LINES = 8192;
    localparam int AW    = $clog2(LINES);
    localparam int MW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    req;
    logic [AW-1:0] addr0, addr1;
    logic [3:0]    be0, be1;
    logic [31:0]   wdata0, wdata1;

    logic [1:0]    gnt_o       [2];
    logic [1:0]    rvalid_o    [2];
    logic [31:0]   rdata_o     [2];
    logic [AW-1:0] ram_addr_o  [2];
    logic          ram_en_o    [2];
    logic [3:0]    ram_be_o    [2];
    logic [31:0]   ram_wdata_o [2];
    logic [31:0]   ram_rdata_o [2];

    bram_port_arbiter #(.LINES(LINES), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_o[0]), .rvalid(rvalid_o[0]), .rdata(rdata_o[0]),
        .ram_addr(ram_addr_o[0]), .ram_en(ram_en_o[0]), .ram_be(ram_be_o[0]),
        .ram_wdata(ram_wdata_o[0]), .ram_rdata(ram_rdata_o[0])
    );

    bram_port_arbiter #(.LINES(LINES), .FIXED_PRIORITY(1), .MAX_WAIT(MW)) u_fp (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_o[1]), .rvalid(rvalid_o[1]), .rdata(rdata_o[1]),
        .ram_addr(ram_addr_o[1]), .ram_en(ram_en_o[1]), .ram_be(ram_be_o[1]),
        .ram_wdata(ram_wdata_o[1]), .ram_rdata(ram_rdata_o[1])
    );

    // Byte-enable block RAM behind each instance, one-cycle read latency.
    for (genvar k = 0; k < 2; k++) begin : g_ram
        logic [31:0] mem [LINES];
        initial for (int j = 0; j < LINES; j++) mem[j] = 32'd0;
        always @(posedge clk) begin
            if (ram_en_o[k]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[k][b]) mem[ram_addr_o[k]][8*b +: 8] <= ram_wdata_o[k][8*b +: 8];
                ram_rdata_o[k] <= mem[ram_addr_o[k]];
            end
        end
    end

    // Reference model state, one set per instance.
    int          last_m  [2];   // requester granted most recently
    int          waits_m [2];   // loader cycles waited, capped at MW+1
    logic [1:0]  pend_v  [2];   // expected rvalid for the coming cycle
    logic [31:0] pend_d  [2];
    logic [31:0] mmem    [2][LINES];
    logic [1:0]  obs_gnt [2];

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_gnt(input int k, input logic [1:0] r);
        if (r != 2'b11) return r;
        if (k == 0) return (last_m[0] == 1) ? 2'b01 : 2'b10;
        return (waits_m[1] == MW + 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            last_m[k]  = 1;
            waits_m[k] = 0;
            pend_v[k]  = 2'b00;
            pend_d[k]  = 32'd0;
        end
    endfunction

    // One clock cycle: compare both instances at the falling edge, advance the model.
    task automatic cycle();
        logic [1:0]    rq, eg, erv;
        logic [AW-1:0] wa;
        logic [3:0]    wbe;
        logic [31:0]   wd;
        int            w;
        @(negedge clk);
        rq = rst ? 2'b00 : req;
        for (int k = 0; k < 2; k++) begin
            eg = model_gnt(k, rq);
            obs_gnt[k] = gnt_o[k];
            w   = eg[1] ? 1 : 0;
            wa  = (eg == 2'b00) ? '0 : (w == 1 ? addr1 : addr0);
            wbe = (eg == 2'b00) ? '0 : (w == 1 ? be1 : be0);
            wd  = (eg == 2'b00) ? '0 : (w == 1 ? wdata1 : wdata0);
            check(k == 0 ? "rr_gnt" : "fp_gnt", 32'(gnt_o[k]), 32'(eg));
            check(k == 0 ? "rr_ram_en" : "fp_ram_en", 32'(ram_en_o[k]), 32'(eg != 2'b00));
            check(k == 0 ? "rr_ram_addr" : "fp_ram_addr", 32'(ram_addr_o[k]), 32'(wa));
            check(k == 0 ? "rr_ram_be" : "fp_ram_be", 32'(ram_be_o[k]), 32'(wbe));
            check(k == 0 ? "rr_ram_wdata" : "fp_ram_wdata", ram_wdata_o[k], wd);
            erv = rst ? 2'b00 : pend_v[k];
            check(k == 0 ? "rr_rvalid" : "fp_rvalid", 32'(rvalid_o[k]), 32'(erv));
            if (erv != 2'b00)
                check(k == 0 ? "rr_rdata" : "fp_rdata", rdata_o[k], pend_d[k]);
            if (!rst) begin
                pend_v[k] = 2'b00;
                if (eg != 2'b00) begin
                    if (wbe == 4'd0) begin
                        pend_v[k][w] = 1'b1;
                        pend_d[k]    = mmem[k][wa];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (wbe[b]) mmem[k][wa][8*b +: 8] = wd[8*b +: 8];
                    end
                    last_m[k] = w;
                end
                if (eg[1])
                    waits_m[k] = 0;
                else if (rq[1] && waits_m[k] < MW + 1)
                    waits_m[k] = waits_m[k] + 1;
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i);
        logic [AW-1:0] a;
        logic [3:0]    b;
        logic [31:0]   d;
        a = AW'($urandom_range(0, 15));
        b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        d = $urandom;
        if (i == 0) begin
            req[0] = ($urandom_range(0, 9) < 6); addr0 = a; be0 = b; wdata0 = d;
        end else begin
            req[1] = ($urandom_range(0, 9) < 6); addr1 = a; be1 = b; wdata1 = d;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < LINES; j++) mmem[k][j] = 32'd0;
        model_reset();
        rst = 1'b1; req = 2'b11;
        addr0 = AW'(1); addr1 = AW'(2); be0 = 4'd0; be1 = 4'd0;
        wdata0 = 32'd0; wdata1 = 32'd0;

        // Reset held with both requesting: nothing may be granted.
        repeat (3) cycle();
        check("rst_gnt_rr", 32'(obs_gnt[0]), 32'd0);
        check("rst_gnt_fp", 32'(obs_gnt[1]), 32'd0);
        rst = 1'b0;

        // Continuous contention straight out of reset.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("rr_pattern", 32'(obs_gnt[0]), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("fp_pattern", 32'(obs_gnt[1]), (i % 5 == 4) ? 32'd2 : 32'd1);
            check("rr_rvalid_pattern", 32'(rvalid_o[0]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        req = 2'b00;
        cycle();

        // Write then read the same word from the CPU.
        req = 2'b01; addr0 = AW'('h010); be0 = 4'hF; wdata0 = 32'hDEADBEEF;
        cycle();
        check("wr_gnt", 32'(obs_gnt[0]), 32'd1);
        be0 = 4'h0;
        cycle();
        check("rd_gnt", 32'(obs_gnt[0]), 32'd1);
        check("rd_rvalid", 32'(rvalid_o[0]), 32'd1);
        check("rd_rdata", rdata_o[0], 32'hDEADBEEF);
        req = 2'b00;
        cycle();

        // Partial byte write from the loader over a preloaded word.
        req = 2'b01; addr0 = AW'('h020); be0 = 4'hF; wdata0 = 32'h11223344;
        cycle();
        req = 2'b10; addr1 = AW'('h020); be1 = 4'b0010; wdata1 = 32'h0000AA00;
        cycle();
        be1 = 4'h0;
        cycle();
        check("be_rvalid", 32'(rvalid_o[0]), 32'd2);
        check("be_rdata", rdata_o[0], 32'h1122AA44);
        req = 2'b00;
        cycle();

        // Reset arriving with a read in flight drops it at once.
        req = 2'b01; addr0 = AW'('h010); be0 = 4'h0;
        cycle();
        req = 2'b00;
        rst = 1'b1;
        #1;
        check("rst_drop_rvalid", 32'(rvalid_o[0]), 32'd0);
        cycle();
        rst = 1'b0;
        repeat (2) cycle();
        check("post_rst_idle", 32'(obs_gnt[0]), 32'd0);

        // Randomized traffic: requesters hold until granted, sometimes withdraw.
        new_req(0); new_req(1);
        for (int n = 0; n < 400; n++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || obs_gnt[0][i] || $urandom_range(0, 9) == 0)
                    new_req(i);
            end
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
